// File: rtl/cmos_frame_tx.sv
// CMOS-style camera frame source: vsync/href timing with RGB565 colour bars or a
// counter pattern, one byte per clock, high byte first.
module cmos_frame_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pattern_sel,
  output logic       cmos_vsync,
  output logic       cmos_href,
  output logic [7:0] cmos_db,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HREF_LEN = 2 * H_ACTIVE;
  localparam int BAR_LEN  = H_ACTIVE / 8;
  localparam int V_MAX_A  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int HC_W     = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int VC_W     = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam int BX_W     = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  function automatic logic [15:0] bar_pixel(input logic [2:0] bar);
    case (bar)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  state_t            state_p0, state_nxt;
  logic [HC_W-1:0]   hcnt_p0;
  logic [VC_W-1:0]   vcnt_p0;
  logic [BX_W-1:0]   bx_p0;
  logic [2:0]        bar_p0;
  logic              pat_p0;
  logic [7:0]        fcnt_p0;

  logic              line_end, phase_last_line, phase_end, in_href, frame_start;
  logic [15:0]       pix_c;
  logic              vsync_c, busy_c, done_c;
  logic [7:0]        db_c;

  logic              vsync_p1, vld_p1, busy_p1, done_p1;
  logic [7:0]        db_p1;

  assign line_end  = (hcnt_p0 == HC_W'(LINE_LEN - 1));
  assign in_href   = (state_p0 == ACTIVE) && ({1'b0, hcnt_p0} < (HC_W + 1)'(HREF_LEN));
  assign phase_end = line_end && phase_last_line;
  assign frame_start = enable && ((state_p0 == IDLE) || ((state_p0 == VFRONT) && phase_end));

  always_comb begin
    phase_last_line = 1'b0;
    case (state_p0)
      VSYNC:   phase_last_line = (vcnt_p0 == VC_W'(VSYNC_LINES - 1));
      VBACK:   phase_last_line = (vcnt_p0 == VC_W'(V_BACK - 1));
      ACTIVE:  phase_last_line = (vcnt_p0 == VC_W'(V_ACTIVE - 1));
      VFRONT:  phase_last_line = (vcnt_p0 == VC_W'(V_FRONT - 1));
      default: phase_last_line = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (enable)    state_nxt = VSYNC;
      VSYNC:   if (phase_end) state_nxt = VBACK;
      VBACK:   if (phase_end) state_nxt = ACTIVE;
      ACTIVE:  if (phase_end) state_nxt = VFRONT;
      VFRONT:  if (phase_end) state_nxt = enable ? VSYNC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: frame state, line/pixel counters, latched pattern and frame count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      hcnt_p0  <= '0;
      vcnt_p0  <= '0;
      bx_p0    <= '0;
      bar_p0   <= '0;
      pat_p0   <= 1'b0;
      fcnt_p0  <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (frame_start)
        pat_p0 <= pattern_sel;
      if (state_p0 == IDLE || line_end)
        hcnt_p0 <= '0;
      else
        hcnt_p0 <= hcnt_p0 + HC_W'(1);
      if (state_p0 == IDLE || phase_end)
        vcnt_p0 <= '0;
      else if (line_end)
        vcnt_p0 <= vcnt_p0 + VC_W'(1);
      // Bar index steps after the low byte of the last pixel in each bar
      if (!in_href) begin
        bx_p0  <= '0;
        bar_p0 <= '0;
      end else if (hcnt_p0[0]) begin
        if (bx_p0 == BX_W'(BAR_LEN - 1)) begin
          bx_p0  <= '0;
          bar_p0 <= bar_p0 + 3'd1;
        end else begin
          bx_p0  <= bx_p0 + BX_W'(1);
        end
      end
      if (state_p0 == VFRONT && phase_end)
        fcnt_p0 <= fcnt_p0 + 8'd1;
    end
  end

  always_comb begin
    vsync_c = (state_p0 == VSYNC);
    busy_c  = (state_p0 != IDLE);
    done_c  = (state_p0 == VFRONT) && phase_end;
    if (pat_p0)
      pix_c = 16'(hcnt_p0 >> 1) + 16'(vcnt_p0) + {8'h00, fcnt_p0};
    else
      pix_c = bar_pixel(bar_p0);
    db_c = 8'h00;
    if (in_href)
      db_c = hcnt_p0[0] ? pix_c[7:0] : pix_c[15:8];
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      db_p1    <= 8'h00;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      vsync_p1 <= vsync_c;
      vld_p1   <= in_href;
      db_p1    <= db_c;
      busy_p1  <= busy_c;
      done_p1  <= done_c;
    end
  end

  assign cmos_vsync = vsync_p1;
  assign cmos_href  = vld_p1;
  assign cmos_db    = db_p1;
  assign busy       = busy_p1;
  assign frame_done = done_p1;
  assign frame_cnt  = fcnt_p0;

endmodule

// File: tb/tb_cmos_frame_tx.sv
// Scoreboard bench for cmos_frame_tx on a 100-clock miniature frame
// (8x2 active, 4 blank clocks, one line each of vsync/back/front porch).
module tb_cmos_frame_tx;
  localparam int HA  = 8;
  localparam int VA  = 2;
  localparam int HB  = 4;
  localparam int VS  = 1;
  localparam int VBK = 1;
  localparam int VF  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       pattern_sel = 1'b0;
  logic       cmos_vsync, cmos_href, busy, frame_done;
  logic [7:0] cmos_db, frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nhref = 0;
  logic [7:0]  byte_q[$];
  logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  cmos_frame_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VBK), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_db(cmos_db),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Byte monitor: every href byte is popped from the scoreboard, idle bytes must be zero
  always @(negedge clk) begin
    if (cmos_href) begin
      nhref++;
      if (byte_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL db_unexpected actual=%0h required=none at cycle %0d", cmos_db, cyc);
      end else begin
        check("db", {24'h0, cmos_db}, {24'h0, byte_q.pop_front()});
      end
    end else begin
      check("db_idle", {24'h0, cmos_db}, 32'h0);
    end
  end

  task automatic push_frame(input bit pat, input int fc);
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        logic [15:0] p;
        if (pat) p = 16'((x + y + fc) % 65536);
        else     p = bars[x / (HA / 8)];
        byte_q.push_back(p[15:8]);
        byte_q.push_back(p[7:0]);
      end
    end
  endtask

  task automatic wait_vsync_rise(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmos_vsync) begin
        t = cyc;
        break;
      end
    end
    checks++;
    if (t < 0) begin
      errors++;
      $display("FAIL vsync_timeout actual=none required=rise");
    end
  endtask

  task automatic vsync_len();
    int n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmos_vsync) n++;
      else break;
    end
    check("vsync_len", n, 20);
  endtask

  task automatic href_line(input int t0, input int exp_start);
    int rise = -1;
    int len = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmos_href) begin
        rise = cyc;
        break;
      end
    end
    if (rise < 0) begin
      checks++;
      errors++;
      $display("FAIL href_timeout actual=none required=rise");
    end else begin
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (cmos_href) len++;
        else break;
      end
      check("href_start", rise - t0, exp_start);
      check("href_len", len, 2 * HA);
    end
  endtask

  task automatic wait_done(input int t0, input int exp_fc, input int h0);
    int lows = 0;
    int td = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) lows++;
      if (frame_done) begin
        td = cyc;
        break;
      end
    end
    if (td < 0) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout actual=none required=pulse");
    end else begin
      check("done_offset", td - t0, 99);
      check("frame_cnt", {24'h0, frame_cnt}, exp_fc);
      check("busy_held", lows, 0);
      check("href_cycles", nhref - h0, 2 * HA * VA);
    end
  endtask

  initial begin
    int t0, t1, t2, h0, n, nv;
    rst_n = 1'b0;
    enable = 1'b0;
    pattern_sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vsync", cmos_vsync, 0);
    check("rst_href", cmos_href, 0);
    check("rst_db", {24'h0, cmos_db}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_fcnt", {24'h0, frame_cnt}, 0);

    // Three back-to-back frames: bars, counter fc=1, counter fc=2 (enable drops mid-way)
    push_frame(1'b0, 0);
    enable = 1'b1;
    rst_n = 1'b1;
    wait_vsync_rise(t0);
    h0 = nhref;
    pattern_sel = 1'b1;
    push_frame(1'b1, 1);
    vsync_len();
    href_line(t0, 40);
    href_line(t0, 60);
    wait_done(t0, 1, h0);

    wait_vsync_rise(t1);
    h0 = nhref;
    check("frame_period_1", t1 - t0, 100);
    push_frame(1'b1, 2);
    vsync_len();
    wait_done(t1, 2, h0);

    wait_vsync_rise(t2);
    h0 = nhref;
    check("frame_period_2", t2 - t1, 100);
    vsync_len();
    while (cyc < t2 + 50) @(negedge clk);
    enable = 1'b0;
    wait_done(t2, 3, h0);
    @(negedge clk);
    check("busy_after_stop", busy, 0);
    check("done_one_cycle", frame_done, 0);
    nv = 0;
    repeat (150) begin
      @(negedge clk);
      if (cmos_vsync || busy) nv++;
    end
    check("idle_quiet", nv, 0);

    // Reset in the middle of an active line, then restart with counter fc=0
    pattern_sel = 1'b0;
    enable = 1'b1;
    push_frame(1'b0, 0);
    wait_vsync_rise(t0);
    vsync_len();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmos_href) begin
        n++;
        if (n == 5) break;
      end
    end
    check("href_before_reset", n, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_href", cmos_href, 0);
    check("mid_rst_db", {24'h0, cmos_db}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vsync", cmos_vsync, 0);
    check("mid_rst_fcnt", {24'h0, frame_cnt}, 0);
    byte_q.delete();
    pattern_sel = 1'b1;
    push_frame(1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_vsync_rise(t0);
    h0 = nhref;
    vsync_len();
    wait_done(t0, 1, h0);

    // Run on through frame_cnt 255 -> 0 with the counter pattern
    for (int k = 1; k <= 256; k++) begin
      push_frame(1'b1, k % 256);
      wait_vsync_rise(t0);
      h0 = nhref;
      if (k == 256) enable = 1'b0;
      wait_done(t0, (k + 1) % 256, h0);
    end
    @(negedge clk);
    check("busy_end", busy, 0);
    check("queue_drained", byte_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
